c2h_byp_loopback_q: RTL and testbench
=====================================

// Module: c2h_byp_loopback_q
// PURPOSE
//  Buffered successor to the C2H descriptor-bypass loopback. It sits between the QDMA c2h_byp_out_* and c2h_byp_in_{mm,st_csh}_* ports.
//  Routes bypassed descriptors into per-path FIFOs of parametrised depth, so the upstream ready no longer depends on downstream ready.
//  Registers marker responses and sequences MM marker requests through an ordered FSM with a timeout.
// PARAMETERS
//  DSC_W    256   descriptor width; MM wadr taken from [191:128], so DSC_W>=192
//  QID_W    11    queue-id width
//  DEPTH    8     entries per FIFO (MM, ST); power of 2, >=2
//  MRKR_TO  1023  cycles to wait for an MM marker response before timeout
// PORTS
//  axi_aclk                 in   1      clock
//  axi_areset               in   1      synchronous, active-high reset
//  c2h_dsc_bypass           in   2      01 = cache/MM bypass, 10 = simple bypass, else disabled
//  c2h_mm_marker_req        in   1      single-cycle request to inject an MM marker
//  pfch_byp_tag             in   7      prefetch tag used in simple bypass
//  c2h_byp_out_{dsc,fmt,st_mm,qid,error,func,cidx,port_id,pfch_tag}  in  DSC_W/3/1/QID_W/1/8/16/3/7  bypass-out descriptor + sideband
//  c2h_byp_out_vld          in   1      upstream valid
//  c2h_byp_out_rdy          out  1      upstream ready
//  c2h_byp_in_mm_{radr,wadr,len,sdi,qid,error,func,cidx,port_id}  out  64/64/16/1/QID_W/1/8/16/3  head of MM FIFO
//  c2h_byp_in_mm_{mrkr_req,no_dma}  out  1/1  high only while the FSM drives a marker
//  c2h_byp_in_mm_vld        out  1      MM valid
//  c2h_byp_in_mm_rdy        in   1      MM ready
//  c2h_byp_in_st_csh_{addr,qid,error,func,port_id,pfch_tag}  out  64/QID_W/1/8/3/7  head of ST FIFO
//  c2h_byp_in_st_csh_vld    out  1      ST valid
//  c2h_byp_in_st_csh_rdy    in   1      ST ready
//  c2h_{st,mm}_marker_rsp   out  1      registered 1-cycle marker-response pulses
//  mm_occ, st_occ           out  $clog2(DEPTH+1)  FIFO occupancy
//  mrkr_busy                out  1      marker FSM not IDLE
//  mrkr_timeout             out  1      sticky; cleared only by reset
// BEHAVIOUR
//  Reset: FIFOs flushed; occupancies 0; FSM IDLE; all outputs 0, including c2h_byp_out_rdy.
//  Marker response (fmt==3'b001):
//   - rdy=1 in any mode; never queued.
//   - Next cycle, pulse c2h_mm_marker_rsp if st_mm=1, else c2h_st_marker_rsp.
//  Descriptor (fmt!=1), st_mm=1:
//   - rdy = mode 01 & MM FIFO not full & FSM in IDLE or WAIT.
//  Descriptor (fmt!=1), st_mm=0:
//   - rdy = mode in {01,10} & ST FIFO not full.
//  Disabled mode: rdy=0 for descriptors.
//  Push on vld&rdy; field mapping:
//   - MM: radr=dsc[63:0], wadr=dsc[191:128], len=dsc[79:64], sdi=dsc[94].
//   - ST: addr=dsc[63:0].
//   - ST pfch_tag = pfch_byp_tag if mode==10 at push, else c2h_byp_out_pfch_tag.
//  Latency: a push in cycle N is visible on the output vld at N+1. Output vld = !empty; pop on vld&rdy.
//  Full FIFO: rdy=0 even if a pop occurs the same cycle (no bypass of full).
//  Push and pop in the same cycle on a non-full FIFO: occupancy unchanged.
//  Output fields are stable while vld&!rdy.
//  Mode change affects only new pushes; queued entries drain unchanged.
//  MM marker FSM:
//   - IDLE->DRAIN on c2h_mm_marker_req; requests while not IDLE are ignored.
//   - DRAIN: MM pushes blocked; MM FIFO keeps draining; ->REQ when mm_occ==0.
//   - REQ: drive mm_vld=1, mrkr_req=1, no_dma=1, len=0, other fields 0; ->WAIT on mm_rdy.
//   - WAIT: ->IDLE on an MM marker response, or after MRKR_TO cycles (set mrkr_timeout).
//   - A response arriving in the same cycle as the timeout counts as a response; no timeout is set.
//   - A response outside WAIT still pulses c2h_mm_marker_rsp and does not change state.
//  Reset asserted mid-transfer: in-flight entries are discarded and state returns to IDLE on the next edge.
// TESTING
//  1. Mode 01, 3 MM descriptors with mm_rdy=1 -> each appears 1 cycle after accept, fields sliced as above, mm_occ returns to 0.
//  2. Mode 10, mm_rdy=0, ST rdy=0, push 8 ST descriptors (DEPTH=8) -> st_occ=8, rdy drops after the 8th; pfch_tag=pfch_byp_tag; pop one -> rdy=1 next cycle.
//  3. fmt=1, st_mm=1, vld for 1 cycle in mode 00 -> rdy=1; c2h_mm_marker_rsp pulses exactly 1 cycle later; no FIFO change.
//  4. mm_occ=2, pulse marker_req -> MM pushes blocked; marker driven after 2 pops with no_dma=1, len=0; response returns FSM to IDLE, mrkr_timeout stays 0.
//  5. Marker sent, no response for MRKR_TO cycles -> mrkr_timeout=1, FSM IDLE, subsequent MM pushes accepted.
//  6. Reset asserted with both FIFOs half full and FSM in WAIT -> next cycle occupancies 0, all vld 0, mrkr_busy 0, mrkr_timeout 0.

Source files
------------

// File: rtl/c2h_byp_loopback_q.sv
// Buffered C2H descriptor-bypass loopback: per-path FIFOs between c2h_byp_out_* and
// c2h_byp_in_{mm,st_csh}_*, registered marker responses and an ordered MM marker FSM.

module c2h_byp_loopback_q_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic                       vld_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] occ_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [OCC_W-1:0] occ_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            occ_q   <= '0;
        end else begin
            if (push_i) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (pop_i)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            occ_q <= occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wrPtr_q] <= data_i;
    end

    // Head is forced to zero when empty so idle outputs read as 0.
    assign vld_o  = (occ_q != '0);
    assign full_o = (occ_q == OCC_W'(DEPTH));
    assign occ_o  = occ_q;
    assign data_o = vld_o ? mem_q[rdPtr_q] : '0;
endmodule

module c2h_byp_loopback_q #(
    parameter int DSC_W   = 256,
    parameter int QID_W   = 11,
    parameter int DEPTH   = 8,
    parameter int MRKR_TO = 1023
) (
    input  logic                       axi_aclk,
    input  logic                       axi_areset,
    input  logic [1:0]                 c2h_dsc_bypass,
    input  logic                       c2h_mm_marker_req,
    input  logic [6:0]                 pfch_byp_tag,
    input  logic [DSC_W-1:0]           c2h_byp_out_dsc,
    input  logic [2:0]                 c2h_byp_out_fmt,
    input  logic                       c2h_byp_out_st_mm,
    input  logic [QID_W-1:0]           c2h_byp_out_qid,
    input  logic                       c2h_byp_out_error,
    input  logic [7:0]                 c2h_byp_out_func,
    input  logic [15:0]                c2h_byp_out_cidx,
    input  logic [2:0]                 c2h_byp_out_port_id,
    input  logic [6:0]                 c2h_byp_out_pfch_tag,
    input  logic                       c2h_byp_out_vld,
    output logic                       c2h_byp_out_rdy,
    output logic [63:0]                c2h_byp_in_mm_radr,
    output logic [63:0]                c2h_byp_in_mm_wadr,
    output logic [15:0]                c2h_byp_in_mm_len,
    output logic                       c2h_byp_in_mm_sdi,
    output logic [QID_W-1:0]           c2h_byp_in_mm_qid,
    output logic                       c2h_byp_in_mm_error,
    output logic [7:0]                 c2h_byp_in_mm_func,
    output logic [15:0]                c2h_byp_in_mm_cidx,
    output logic [2:0]                 c2h_byp_in_mm_port_id,
    output logic                       c2h_byp_in_mm_mrkr_req,
    output logic                       c2h_byp_in_mm_no_dma,
    output logic                       c2h_byp_in_mm_vld,
    input  logic                       c2h_byp_in_mm_rdy,
    output logic [63:0]                c2h_byp_in_st_csh_addr,
    output logic [QID_W-1:0]           c2h_byp_in_st_csh_qid,
    output logic                       c2h_byp_in_st_csh_error,
    output logic [7:0]                 c2h_byp_in_st_csh_func,
    output logic [2:0]                 c2h_byp_in_st_csh_port_id,
    output logic [6:0]                 c2h_byp_in_st_csh_pfch_tag,
    output logic                       c2h_byp_in_st_csh_vld,
    input  logic                       c2h_byp_in_st_csh_rdy,
    output logic                       c2h_st_marker_rsp,
    output logic                       c2h_mm_marker_rsp,
    output logic [$clog2(DEPTH+1)-1:0] mm_occ,
    output logic [$clog2(DEPTH+1)-1:0] st_occ,
    output logic                       mrkr_busy,
    output logic                       mrkr_timeout
);
    localparam int MM_W = 64 + 64 + 16 + 1 + QID_W + 1 + 8 + 16 + 3;
    localparam int ST_W = 64 + QID_W + 1 + 8 + 3 + 7;
    localparam int TO_W = $clog2(MRKR_TO + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_REQ   = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] toCnt_q, toCnt_d;
    logic            timeout_q, timeout_d;
    logic            mmRsp_q, stRsp_q;

    logic            isMrkr, bypAcc, mmPush, stPush, mmRspIn, stRspIn;
    logic            mmFull, stFull, mmFifoVld, stFifoVld, mmPop, stPop;
    logic [MM_W-1:0] mmDin, mmDout;
    logic [ST_W-1:0] stDin, stDout;
    logic [6:0]      stPfchIn;
    logic            unused_dsc;

    assign isMrkr  = (c2h_byp_out_fmt == 3'b001);
    assign bypAcc  = c2h_byp_out_vld & c2h_byp_out_rdy;
    assign mmPush  = bypAcc & ~isMrkr & c2h_byp_out_st_mm;
    assign stPush  = bypAcc & ~isMrkr & ~c2h_byp_out_st_mm;
    assign mmRspIn = bypAcc & isMrkr & c2h_byp_out_st_mm;
    assign stRspIn = bypAcc & isMrkr & ~c2h_byp_out_st_mm;

    // Markers are always accepted; MM pushes stall while the FSM is draining or driving a marker.
    always_comb begin
        c2h_byp_out_rdy = 1'b0;
        if (!axi_areset) begin
            if (isMrkr)
                c2h_byp_out_rdy = 1'b1;
            else if (c2h_byp_out_st_mm)
                c2h_byp_out_rdy = (c2h_dsc_bypass == 2'b01) && !mmFull &&
                                  ((state_q == S_IDLE) || (state_q == S_WAIT));
            else
                c2h_byp_out_rdy = ((c2h_dsc_bypass == 2'b01) || (c2h_dsc_bypass == 2'b10)) && !stFull;
        end
    end

    assign stPfchIn = (c2h_dsc_bypass == 2'b10) ? pfch_byp_tag : c2h_byp_out_pfch_tag;
    assign mmDin = {c2h_byp_out_dsc[63:0], c2h_byp_out_dsc[191:128], c2h_byp_out_dsc[79:64],
                    c2h_byp_out_dsc[94], c2h_byp_out_qid, c2h_byp_out_error, c2h_byp_out_func,
                    c2h_byp_out_cidx, c2h_byp_out_port_id};
    assign stDin = {c2h_byp_out_dsc[63:0], c2h_byp_out_qid, c2h_byp_out_error,
                    c2h_byp_out_func, c2h_byp_out_port_id, stPfchIn};
    assign unused_dsc = ^c2h_byp_out_dsc;

    assign mmPop = mmFifoVld & c2h_byp_in_mm_rdy;
    assign stPop = stFifoVld & c2h_byp_in_st_csh_rdy;

    c2h_byp_loopback_q_fifo #(.W(MM_W), .DEPTH(DEPTH)) u_mmFifo (
        .clk_i(axi_aclk), .reset_i(axi_areset), .push_i(mmPush), .data_i(mmDin),
        .pop_i(mmPop), .data_o(mmDout), .vld_o(mmFifoVld), .full_o(mmFull), .occ_o(mm_occ)
    );

    c2h_byp_loopback_q_fifo #(.W(ST_W), .DEPTH(DEPTH)) u_stFifo (
        .clk_i(axi_aclk), .reset_i(axi_areset), .push_i(stPush), .data_i(stDin),
        .pop_i(stPop), .data_o(stDout), .vld_o(stFifoVld), .full_o(stFull), .occ_o(st_occ)
    );

    // The FIFO is empty in S_REQ, so its zeroed head already supplies the marker's zero fields.
    assign {c2h_byp_in_mm_radr, c2h_byp_in_mm_wadr, c2h_byp_in_mm_len, c2h_byp_in_mm_sdi,
            c2h_byp_in_mm_qid, c2h_byp_in_mm_error, c2h_byp_in_mm_func, c2h_byp_in_mm_cidx,
            c2h_byp_in_mm_port_id} = mmDout;
    assign c2h_byp_in_mm_mrkr_req = (state_q == S_REQ);
    assign c2h_byp_in_mm_no_dma   = (state_q == S_REQ);
    assign c2h_byp_in_mm_vld      = mmFifoVld | (state_q == S_REQ);

    assign {c2h_byp_in_st_csh_addr, c2h_byp_in_st_csh_qid, c2h_byp_in_st_csh_error,
            c2h_byp_in_st_csh_func, c2h_byp_in_st_csh_port_id, c2h_byp_in_st_csh_pfch_tag} = stDout;
    assign c2h_byp_in_st_csh_vld = stFifoVld;

    // A response in the final WAIT cycle beats the timeout.
    always_comb begin
        state_d   = state_q;
        toCnt_d   = toCnt_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE:  if (c2h_mm_marker_req) state_d = S_DRAIN;
            S_DRAIN: if (mm_occ == '0) state_d = S_REQ;
            S_REQ: begin
                if (c2h_byp_in_mm_rdy) begin
                    state_d = S_WAIT;
                    toCnt_d = '0;
                end
            end
            S_WAIT: begin
                if (mmRspIn) begin
                    state_d = S_IDLE;
                end else if (toCnt_q == TO_W'(MRKR_TO - 1)) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    toCnt_d = toCnt_q + TO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q   <= S_IDLE;
            toCnt_q   <= '0;
            timeout_q <= 1'b0;
            mmRsp_q   <= 1'b0;
            stRsp_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            toCnt_q   <= toCnt_d;
            timeout_q <= timeout_d;
            mmRsp_q   <= mmRspIn;
            stRsp_q   <= stRspIn;
        end
    end

    assign c2h_mm_marker_rsp = mmRsp_q;
    assign c2h_st_marker_rsp = stRsp_q;
    assign mrkr_busy         = (state_q != S_IDLE);
    assign mrkr_timeout      = timeout_q;
endmodule

// File: tb/tb_c2h_byp_loopback_q.sv
// Directed self-checking bench for c2h_byp_loopback_q: MM/ST data paths, full handling,
// marker responses, the MM marker FSM including timeout and tie cases, and mid-run reset.

module tb_c2h_byp_loopback_q;
    localparam int DSC_W   = 256;
    localparam int QID_W   = 11;
    localparam int DEPTH   = 8;
    localparam int MRKR_TO = 1023;
    localparam int OCC_W   = $clog2(DEPTH+1);

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         mode;
    logic               markerReq;
    logic [6:0]         pfchBypTag;
    logic [DSC_W-1:0]   dsc;
    logic [2:0]         fmt;
    logic               stMm;
    logic [QID_W-1:0]   qid;
    logic               outVld;
    logic               outRdy;
    logic [63:0]        mmRadr, mmWadr;
    logic [15:0]        mmLen;
    logic               mmSdi;
    logic [QID_W-1:0]   mmQid;
    logic               mmError;
    logic [7:0]         mmFunc;
    logic [15:0]        mmCidx;
    logic [2:0]         mmPortId;
    logic               mmMrkrReq, mmNoDma, mmVld, mmRdy;
    logic [63:0]        stAddr;
    logic [QID_W-1:0]   stQid;
    logic               stError;
    logic [7:0]         stFunc;
    logic [2:0]         stPortId;
    logic [6:0]         stPfchTag;
    logic               stVld, stRdy;
    logic               stMrkrRsp, mmMrkrRsp;
    logic [OCC_W-1:0]   mmOcc, stOcc;
    logic               mrkrBusy, mrkrTimeout;

    int compared   = 0;
    int mismatched = 0;

    logic [DSC_W-1:0] d1, d2, d3;

    c2h_byp_loopback_q #(.DSC_W(DSC_W), .QID_W(QID_W), .DEPTH(DEPTH), .MRKR_TO(MRKR_TO)) dut (
        .axi_aclk(clk), .axi_areset(reset), .c2h_dsc_bypass(mode),
        .c2h_mm_marker_req(markerReq), .pfch_byp_tag(pfchBypTag),
        .c2h_byp_out_dsc(dsc), .c2h_byp_out_fmt(fmt), .c2h_byp_out_st_mm(stMm),
        .c2h_byp_out_qid(qid), .c2h_byp_out_error(1'b1), .c2h_byp_out_func(8'h5A),
        .c2h_byp_out_cidx(16'h1234), .c2h_byp_out_port_id(3'h5), .c2h_byp_out_pfch_tag(7'h11),
        .c2h_byp_out_vld(outVld), .c2h_byp_out_rdy(outRdy),
        .c2h_byp_in_mm_radr(mmRadr), .c2h_byp_in_mm_wadr(mmWadr), .c2h_byp_in_mm_len(mmLen),
        .c2h_byp_in_mm_sdi(mmSdi), .c2h_byp_in_mm_qid(mmQid), .c2h_byp_in_mm_error(mmError),
        .c2h_byp_in_mm_func(mmFunc), .c2h_byp_in_mm_cidx(mmCidx), .c2h_byp_in_mm_port_id(mmPortId),
        .c2h_byp_in_mm_mrkr_req(mmMrkrReq), .c2h_byp_in_mm_no_dma(mmNoDma),
        .c2h_byp_in_mm_vld(mmVld), .c2h_byp_in_mm_rdy(mmRdy),
        .c2h_byp_in_st_csh_addr(stAddr), .c2h_byp_in_st_csh_qid(stQid),
        .c2h_byp_in_st_csh_error(stError), .c2h_byp_in_st_csh_func(stFunc),
        .c2h_byp_in_st_csh_port_id(stPortId), .c2h_byp_in_st_csh_pfch_tag(stPfchTag),
        .c2h_byp_in_st_csh_vld(stVld), .c2h_byp_in_st_csh_rdy(stRdy),
        .c2h_st_marker_rsp(stMrkrRsp), .c2h_mm_marker_rsp(mmMrkrRsp),
        .mm_occ(mmOcc), .st_occ(stOcc), .mrkr_busy(mrkrBusy), .mrkr_timeout(mrkrTimeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] f, input logic sm,
                                 input logic [DSC_W-1:0] d, input logic [QID_W-1:0] q);
        outVld = v;
        fmt    = f;
        stMm   = sm;
        dsc    = d;
        qid    = q;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [DSC_W-1:0] mkDsc(input logic [63:0] radr, input logic [63:0] wadr,
                                               input logic [15:0] len, input logic sdi);
        logic [DSC_W-1:0] d;
        d          = '1;
        d[63:0]    = radr;
        d[79:64]   = len;
        d[94]      = sdi;
        d[191:128] = wadr;
        return d;
    endfunction

    // Takes the FSM from IDLE with an empty MM FIFO into WAIT.
    task automatic enterWait();
        markerReq = 1'b1;
        tick();
        markerReq = 1'b0;
        checkOutput("enter drain busy", mrkrBusy, 1);
        tick();
        checkOutput("enter req mrkr_req", mmMrkrReq, 1);
        mmRdy = 1'b1;
        tick();
        mmRdy = 1'b0;
        checkOutput("enter wait mm_vld", mmVld, 0);
    endtask

    initial begin
        reset = 1'b1; mode = 2'b00; markerReq = 1'b0; pfchBypTag = 7'h6C;
        mmRdy = 1'b0; stRdy = 1'b0;
        applyStimulus(1'b1, 3'b001, 1'b1, '0, '0);
        tick(); tick();
        checkOutput("reset rdy", outRdy, 0);
        checkOutput("reset mm_rsp", mmMrkrRsp, 0);
        applyStimulus(1'b0, 3'b000, 1'b0, '0, '0);
        reset = 1'b0;
        #1;
        checkOutput("reset mm_occ", mmOcc, 0);
        checkOutput("reset st_occ", stOcc, 0);
        checkOutput("reset mm_vld", mmVld, 0);
        checkOutput("reset st_vld", stVld, 0);
        checkOutput("reset busy", mrkrBusy, 0);
        checkOutput("reset timeout", mrkrTimeout, 0);

        $display("[TB] test 1: MM path");
        d1 = mkDsc(64'h1111_0000_0000_0001, 64'h2222_0000_0000_0001, 16'h0040, 1'b1);
        d2 = mkDsc(64'h1111_0000_0000_0002, 64'h2222_0000_0000_0002, 16'h0080, 1'b0);
        d3 = mkDsc(64'h1111_0000_0000_0003, 64'h2222_0000_0000_0003, 16'h0100, 1'b1);
        mode = 2'b01; mmRdy = 1'b1;
        applyStimulus(1'b1, 3'b000, 1'b1, d1, 11'd1);
        checkOutput("t1 rdy", outRdy, 1);
        checkOutput("t1 mm_vld before", mmVld, 0);
        tick();
        applyStimulus(1'b1, 3'b000, 1'b1, d2, 11'd2);
        checkOutput("t1 d1 vld", mmVld, 1);
        checkOutput("t1 d1 radr", mmRadr, 64'h1111_0000_0000_0001);
        checkOutput("t1 d1 wadr", mmWadr, 64'h2222_0000_0000_0001);
        checkOutput("t1 d1 len", mmLen, 16'h0040);
        checkOutput("t1 d1 sdi", mmSdi, 1);
        checkOutput("t1 d1 qid", mmQid, 1);
        checkOutput("t1 d1 err", mmError, 1);
        checkOutput("t1 d1 func", mmFunc, 8'h5A);
        checkOutput("t1 d1 cidx", mmCidx, 16'h1234);
        checkOutput("t1 d1 port", mmPortId, 3'h5);
        checkOutput("t1 d1 mrkr", mmMrkrReq, 0);
        checkOutput("t1 d1 occ", mmOcc, 1);
        tick();
        applyStimulus(1'b1, 3'b000, 1'b1, d3, 11'd3);
        checkOutput("t1 d2 radr", mmRadr, 64'h1111_0000_0000_0002);
        checkOutput("t1 d2 len", mmLen, 16'h0080);
        checkOutput("t1 d2 sdi", mmSdi, 0);
        checkOutput("t1 d2 qid", mmQid, 2);
        checkOutput("t1 d2 occ", mmOcc, 1);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b1, '0, '0);
        checkOutput("t1 d3 radr", mmRadr, 64'h1111_0000_0000_0003);
        checkOutput("t1 d3 wadr", mmWadr, 64'h2222_0000_0000_0003);
        checkOutput("t1 d3 sdi", mmSdi, 1);
        tick();
        checkOutput("t1 final occ", mmOcc, 0);
        checkOutput("t1 final vld", mmVld, 0);

        $display("[TB] test 2: ST fill and full");
        mode = 2'b10; mmRdy = 1'b0; stRdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 3'b000, 1'b0, mkDsc(64'hA000_0000_0000_0000 + 64'(i), '0, '0, 1'b0), 11'h100 + 11'(i));
            checkOutput("t2 fill rdy", outRdy, 1);
            tick();
        end
        applyStimulus(1'b1, 3'b000, 1'b0, mkDsc(64'hA000_0000_0000_0008, '0, '0, 1'b0), 11'h108);
        checkOutput("t2 full occ", stOcc, 8);
        checkOutput("t2 full rdy", outRdy, 0);
        checkOutput("t2 head vld", stVld, 1);
        checkOutput("t2 head addr", stAddr, 64'hA000_0000_0000_0000);
        checkOutput("t2 head qid", stQid, 11'h100);
        checkOutput("t2 head pfch", stPfchTag, 7'h6C);
        checkOutput("t2 head func", stFunc, 8'h5A);
        checkOutput("t2 head port", stPortId, 3'h5);
        stRdy = 1'b1; #1;
        checkOutput("t2 full pop rdy", outRdy, 0);
        tick();
        stRdy = 1'b0;
        applyStimulus(1'b0, 3'b000, 1'b0, '0, '0);
        checkOutput("t2 after pop occ", stOcc, 7);
        checkOutput("t2 after pop rdy", outRdy, 1);
        checkOutput("t2 after pop addr", stAddr, 64'hA000_0000_0000_0001);
        mode = 2'b01; #1;
        checkOutput("t2 mode change pfch", stPfchTag, 7'h6C);
        stRdy = 1'b1;
        repeat (7) tick();
        stRdy = 1'b0;
        checkOutput("t2 drained occ", stOcc, 0);
        checkOutput("t2 drained vld", stVld, 0);
        applyStimulus(1'b1, 3'b000, 1'b0, mkDsc(64'hB0, '0, '0, 1'b0), 11'h7);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, '0, '0);
        checkOutput("t2 mode01 pfch", stPfchTag, 7'h11);
        stRdy = 1'b1;
        tick();
        stRdy = 1'b0;
        checkOutput("t2 mode01 drained", stOcc, 0);

        $display("[TB] test 3: marker responses");
        mode = 2'b00;
        applyStimulus(1'b1, 3'b000, 1'b0, d1, 11'd5);
        checkOutput("t3 disabled st rdy", outRdy, 0);
        applyStimulus(1'b1, 3'b000, 1'b1, d1, 11'd5);
        checkOutput("t3 disabled mm rdy", outRdy, 0);
        applyStimulus(1'b1, 3'b001, 1'b1, d1, 11'd5);
        checkOutput("t3 marker rdy", outRdy, 1);
        checkOutput("t3 rsp not early", mmMrkrRsp, 0);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, '0, '0);
        checkOutput("t3 mm rsp pulse", mmMrkrRsp, 1);
        checkOutput("t3 st rsp quiet", stMrkrRsp, 0);
        checkOutput("t3 mm occ", mmOcc, 0);
        checkOutput("t3 st occ", stOcc, 0);
        checkOutput("t3 busy", mrkrBusy, 0);
        tick();
        checkOutput("t3 mm rsp end", mmMrkrRsp, 0);
        applyStimulus(1'b1, 3'b001, 1'b0, d1, 11'd5);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, '0, '0);
        checkOutput("t3 st rsp pulse", stMrkrRsp, 1);
        checkOutput("t3 mm rsp quiet", mmMrkrRsp, 0);

        $display("[TB] test 4: marker after drain");
        mode = 2'b01; mmRdy = 1'b0;
        applyStimulus(1'b1, 3'b000, 1'b1, d1, 11'd1);
        tick();
        applyStimulus(1'b1, 3'b000, 1'b1, d2, 11'd2);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, '0, '0);
        checkOutput("t4 occ 2", mmOcc, 2);
        markerReq = 1'b1;
        tick();
        markerReq = 1'b0;
        checkOutput("t4 drain busy", mrkrBusy, 1);
        applyStimulus(1'b1, 3'b000, 1'b1, d3, 11'd3);
        checkOutput("t4 drain push blocked", outRdy, 0);
        applyStimulus(1'b0, 3'b000, 1'b0, '0, '0);
        mmRdy = 1'b1; #1;
        checkOutput("t4 drain head radr", mmRadr, 64'h1111_0000_0000_0001);
        checkOutput("t4 drain no mrkr", mmMrkrReq, 0);
        tick();
        checkOutput("t4 drain occ 1", mmOcc, 1);
        checkOutput("t4 drain head2", mmRadr, 64'h1111_0000_0000_0002);
        tick();
        checkOutput("t4 drain occ 0", mmOcc, 0);
        checkOutput("t4 drain vld 0", mmVld, 0);
        tick();
        checkOutput("t4 req vld", mmVld, 1);
        checkOutput("t4 req mrkr", mmMrkrReq, 1);
        checkOutput("t4 req no_dma", mmNoDma, 1);
        checkOutput("t4 req len", mmLen, 0);
        checkOutput("t4 req radr", mmRadr, 0);
        checkOutput("t4 req wadr", mmWadr, 0);
        tick();
        mmRdy = 1'b0;
        checkOutput("t4 wait busy", mrkrBusy, 1);
        checkOutput("t4 wait vld", mmVld, 0);
        checkOutput("t4 wait mrkr", mmMrkrReq, 0);
        applyStimulus(1'b1, 3'b000, 1'b1, d3, 11'd3);
        checkOutput("t4 wait push ok", outRdy, 1);
        applyStimulus(1'b1, 3'b001, 1'b1, '0, '0);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, '0, '0);
        checkOutput("t4 rsp idle", mrkrBusy, 0);
        checkOutput("t4 rsp pulse", mmMrkrRsp, 1);
        checkOutput("t4 no timeout", mrkrTimeout, 0);

        $display("[TB] test 5: response on last cycle, then timeout");
        enterWait();
        repeat (MRKR_TO - 1) tick();
        checkOutput("t5 tie still busy", mrkrBusy, 1);
        applyStimulus(1'b1, 3'b001, 1'b1, '0, '0);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, '0, '0);
        checkOutput("t5 tie idle", mrkrBusy, 0);
        checkOutput("t5 tie no timeout", mrkrTimeout, 0);
        checkOutput("t5 tie rsp", mmMrkrRsp, 1);
        enterWait();
        repeat (MRKR_TO - 1) tick();
        checkOutput("t5 to still busy", mrkrBusy, 1);
        checkOutput("t5 to not yet", mrkrTimeout, 0);
        tick();
        checkOutput("t5 to idle", mrkrBusy, 0);
        checkOutput("t5 to set", mrkrTimeout, 1);
        applyStimulus(1'b1, 3'b000, 1'b1, d1, 11'd7);
        checkOutput("t5 push rdy", outRdy, 1);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, '0, '0);
        checkOutput("t5 push occ", mmOcc, 1);
        mmRdy = 1'b1;
        tick();
        mmRdy = 1'b0;
        checkOutput("t5 drained", mmOcc, 0);

        $display("[TB] test 6: reset mid-transfer");
        enterWait();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'b000, 1'b1, d2, 11'(i));
            tick();
            applyStimulus(1'b1, 3'b000, 1'b0, d3, 11'(i));
            tick();
        end
        applyStimulus(1'b0, 3'b000, 1'b0, '0, '0);
        checkOutput("t6 mm half", mmOcc, 4);
        checkOutput("t6 st half", stOcc, 4);
        checkOutput("t6 busy", mrkrBusy, 1);
        checkOutput("t6 sticky timeout", mrkrTimeout, 1);
        reset = 1'b1;
        applyStimulus(1'b1, 3'b001, 1'b1, '0, '0);
        checkOutput("t6 reset rdy", outRdy, 0);
        tick();
        checkOutput("t6 mm occ", mmOcc, 0);
        checkOutput("t6 st occ", stOcc, 0);
        checkOutput("t6 mm vld", mmVld, 0);
        checkOutput("t6 st vld", stVld, 0);
        checkOutput("t6 busy", mrkrBusy, 0);
        checkOutput("t6 timeout", mrkrTimeout, 0);
        reset = 1'b0;
        applyStimulus(1'b0, 3'b000, 1'b0, '0, '0);
        tick();
        checkOutput("t6 no rsp", mmMrkrRsp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
